// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte handshake plus the uart_tx start/busy/done port, bundled
// so the arbiter and its neighbours share one connection.
interface uart_tx_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic               tx_start;
    logic [7:0]         tx_data;
    logic               tx_busy;
    logic               tx_done;

    // Arbiter side: accepts requester bytes and drives the transmitter.
    modport slave (
        input  req_valid, req_data, req_last, tx_busy, tx_done,
        output req_ready, tx_start, tx_data
    );

    // Environment side: requesters and the uart_tx itself.
    modport master (
        output req_valid, req_data, req_last, tx_busy, tx_done,
        input  req_ready, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte requesters, with
// packet locking until the last byte and a timeout that frees a stalled owner.
module uart_tx_arbiter #(
    parameter  int unsigned N_REQ        = 4,
    parameter  int unsigned LOCK_TIMEOUT = 1024,
    localparam int unsigned IDW          = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_arbiter_if.slave    bus,
    output logic [IDW-1:0]      grant_id,
    output logic                locked,
    output logic                lock_err
);
    localparam int unsigned TOW = $clog2(LOCK_TIMEOUT);

    typedef enum logic [1:0] {IDLE, ACCEPT, START, WAIT} state_t;

    state_t         state, state_nx;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] cand;
    logic           found;
    logic [TOW-1:0] to_cnt;
    logic [7:0]     tx_data_reg;
    logic           last_reg;
    logic           timeout_hit;

    // Winner search starts one past the last owner; a lock pins it to the owner.
    always_comb begin
        found  = 1'b0;
        winner = grant_id;
        cand   = '0;
        if (locked) begin
            found = bus.req_valid[grant_id];
        end else begin
            for (int unsigned k = 1; k <= N_REQ; k++) begin
                cand = IDW'((ptr + k) % N_REQ);
                if (!found && bus.req_valid[cand]) begin
                    found  = 1'b1;
                    winner = cand;
                end
            end
        end
    end

    assign timeout_hit = (state == IDLE) && locked && !bus.req_valid[grant_id] &&
                         (to_cnt == TOW'(LOCK_TIMEOUT - 1));
    assign lock_err    = timeout_hit;
    assign bus.tx_data = tx_data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        bus.req_ready = '0;
        bus.tx_start  = 1'b0;
        case (state)
            IDLE: begin
                if (found && !bus.tx_busy) state_nx = ACCEPT;
            end
            ACCEPT: begin
                bus.req_ready = N_REQ'(1'b1) << grant_id;
                state_nx      = START;
            end
            START: begin
                bus.tx_start = 1'b1;
                state_nx     = WAIT;
            end
            WAIT: begin
                if (bus.tx_done) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= IDW'(N_REQ - 1);
            grant_id    <= '0;
            locked      <= 1'b0;
            to_cnt      <= '0;
            tx_data_reg <= '0;
            last_reg    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found && !bus.tx_busy) grant_id <= winner;
                end
                ACCEPT: begin
                    tx_data_reg <= bus.req_data[{grant_id, 3'b000} +: 8];
                    last_reg    <= bus.req_last[grant_id];
                end
                WAIT: begin
                    if (bus.tx_done) begin
                        if (last_reg) begin
                            locked <= 1'b0;
                            ptr    <= grant_id;
                        end else begin
                            locked <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            if (timeout_hit) begin
                locked <= 1'b0;
                ptr    <= grant_id;
            end

            // Idle time only accrues while locked and the owner has nothing to send.
            if (state != IDLE || !locked || timeout_hit) to_cnt <= '0;
            else if (!bus.req_valid[grant_id])          to_cnt <= to_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte queues, a small
// uart_tx frame model, and one task per scenario with inline checks.
module tb_uart_tx_arbiter;
    localparam int N     = 4;
    localparam int LT    = 16;
    localparam int FRAME = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();
    logic [1:0] grant_id;
    logic       locked;
    logic       lock_err;

    uart_tx_arbiter #(.N_REQ(N), .LOCK_TIMEOUT(LT)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .grant_id (grant_id),
        .locked   (locked),
        .lock_err (lock_err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Transmitter model: busy the cycle after start, done FRAME-1 cycles later.
    logic mbusy, mdone, force_busy, inj_done;
    int   cnt;
    logic [7:0] log_data [32];
    logic [1:0] log_id   [32];
    logic       log_lock [32];
    int   n_log;
    assign bus.tx_busy = mbusy | force_busy;
    assign bus.tx_done = mdone | inj_done;

    initial begin
        mbusy = 1'b0; mdone = 1'b0; cnt = 0; n_log = 0;
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                mbusy = 1'b0; mdone = 1'b0; cnt = 0; n_log = 0;
            end else if (cnt != 0) begin
                cnt--;
                mdone = (cnt == 1);
                if (cnt == 0) mbusy = 1'b0;
            end else if (bus.tx_start) begin
                mbusy = 1'b1;
                cnt   = FRAME;
                if (n_log < 32) begin
                    log_data[n_log] = bus.tx_data;
                    log_id[n_log]   = grant_id;
                    log_lock[n_log] = locked;
                end
                n_log++;
            end
        end
    end

    // Requester model: each requester presents the head of its queue until accepted.
    logic [8:0] qmem [N][16];
    int         qh [N];
    int         qt [N];
    logic [N-1:0] rdy_seen;

    task automatic push(input int i, input logic [7:0] d, input logic l);
        qmem[i][qt[i] % 16] = {l, d};
        qt[i]++;
    endtask

    initial begin
        logic [N-1:0]   v, l;
        logic [8*N-1:0] d;
        for (int i = 0; i < N; i++) begin qh[i] = 0; qt[i] = 0; end
        bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0;
        forever begin
            @(negedge clk);
            rdy_seen = bus.req_ready;
            @(posedge clk); #1;
            v = '0; l = '0; d = '0;
            for (int i = 0; i < N; i++) begin
                if (rst) begin
                    qh[i] = 0; qt[i] = 0;
                end else if (rdy_seen[i] && qh[i] != qt[i]) begin
                    qh[i]++;
                end
                if (qh[i] != qt[i]) begin
                    v[i]        = 1'b1;
                    d[8*i +: 8] = qmem[i][qh[i] % 16][7:0];
                    l[i]        = qmem[i][qh[i] % 16][8];
                end
            end
            bus.req_valid = v; bus.req_data = d; bus.req_last = l;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; force_busy = 1'b0; inj_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_log(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (n_log >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_quiet(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (n_log >= n && cnt == 0 && !bus.tx_busy) begin ok = 1'b1; break; end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        n_vec++;
        if ({bus.req_ready, bus.tx_start, bus.tx_data, grant_id, locked, lock_err} !== 17'h0) begin
            n_err++;
            $display("FAIL reset_hold: got %h expected 0",
                     {bus.req_ready, bus.tx_start, bus.tx_data, grant_id, locked, lock_err});
        end
        do_reset();
        n_vec++;
        if ({bus.req_ready, bus.tx_start, bus.tx_data, grant_id, locked, lock_err} !== 17'h0) begin
            n_err++;
            $display("FAIL reset_release: got %h expected 0",
                     {bus.req_ready, bus.tx_start, bus.tx_data, grant_id, locked, lock_err});
        end
    endtask

    task automatic test_single_byte();
        bit ok;
        do_reset();
        push(0, 8'h41, 1'b1);
        @(negedge clk);
        n_vec++;
        if (bus.req_ready !== 4'b0000) begin
            n_err++; $display("FAIL single_early_ready: got %b expected 0000", bus.req_ready);
        end
        @(negedge clk);
        n_vec++;
        if ({bus.req_ready, bus.tx_start, grant_id} !== {4'b0001, 1'b0, 2'd0}) begin
            n_err++; $display("FAIL single_accept: got ready %b start %b id %0d expected 0001 0 0",
                              bus.req_ready, bus.tx_start, grant_id);
        end
        @(negedge clk);
        n_vec++;
        if ({bus.req_ready, bus.tx_start, bus.tx_data} !== {4'b0000, 1'b1, 8'h41}) begin
            n_err++; $display("FAIL single_start: got ready %b start %b data %h expected 0000 1 41",
                              bus.req_ready, bus.tx_start, bus.tx_data);
        end
        wait_quiet(1, 40, ok);
        n_vec++;
        if (!ok || n_log !== 1 || log_data[0] !== 8'h41 || locked !== 1'b0) begin
            n_err++; $display("FAIL single_done: got ok %0d frames %0d byte %h locked %b expected 1 1 41 0",
                              ok, n_log, log_data[0], locked);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [1:0] exp_id2 [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
        logic [7:0] exp_d2  [4] = '{8'hB2, 8'hB3, 8'hB0, 8'hB1};
        do_reset();
        for (int i = 0; i < N; i++) push(i, 8'hA0 + 8'(i), 1'b1);
        wait_quiet(4, 200, ok);
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (!ok || log_id[k] !== 2'(k) || log_data[k] !== 8'hA0 + 8'(k)) begin
                n_err++; $display("FAIL rr_first[%0d]: got id %0d data %h expected id %0d data %h",
                                  k, log_id[k], log_data[k], k, 8'hA0 + 8'(k));
            end
        end
        push(1, 8'h51, 1'b1);
        wait_quiet(5, 60, ok);
        n_vec++;
        if (!ok || log_id[4] !== 2'd1) begin
            n_err++; $display("FAIL rr_ptr_setup: got id %0d expected 1", log_id[4]);
        end
        for (int i = 0; i < N; i++) push(i, 8'hB0 + 8'(i), 1'b1);
        wait_quiet(9, 200, ok);
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (!ok || log_id[5+k] !== exp_id2[k] || log_data[5+k] !== exp_d2[k]) begin
                n_err++; $display("FAIL rr_second[%0d]: got id %0d data %h expected id %0d data %h",
                                  k, log_id[5+k], log_data[5+k], exp_id2[k], exp_d2[k]);
            end
        end
    endtask

    task automatic test_packet_lock();
        bit ok;
        logic [1:0] exp_id [4] = '{2'd1, 2'd1, 2'd1, 2'd2};
        logic [7:0] exp_d  [4] = '{8'h10, 8'h11, 8'h12, 8'h20};
        logic       exp_lk [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        push(1, 8'h10, 1'b0);
        push(1, 8'h11, 1'b0);
        push(1, 8'h12, 1'b1);
        push(2, 8'h20, 1'b1);
        wait_quiet(4, 200, ok);
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (!ok || log_id[k] !== exp_id[k] || log_data[k] !== exp_d[k] || log_lock[k] !== exp_lk[k]) begin
                n_err++; $display("FAIL lock_seq[%0d]: got id %0d data %h locked %b expected id %0d data %h locked %b",
                                  k, log_id[k], log_data[k], log_lock[k], exp_id[k], exp_d[k], exp_lk[k]);
            end
        end
        n_vec++;
        if (locked !== 1'b0) begin
            n_err++; $display("FAIL lock_release: got %b expected 0", locked);
        end
    endtask

    task automatic test_lock_timeout();
        bit ok;
        bit seen;
        do_reset();
        push(3, 8'h33, 1'b0);
        wait_log(1, 40, ok);
        push(0, 8'h30, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.tx_done) begin seen = 1'b1; break; end
        end
        n_vec++;
        if (!ok || !seen) begin
            n_err++; $display("FAIL to_first_frame: got start %0d done %0d expected 1 1", ok, seen);
        end
        for (int k = 1; k <= LT; k++) begin
            @(negedge clk);
            n_vec++;
            if (lock_err !== 1'(k == LT) || bus.req_ready !== 4'b0000) begin
                n_err++; $display("FAIL to_wait[%0d]: got lock_err %b ready %b expected %b 0000",
                                  k, lock_err, bus.req_ready, 1'(k == LT));
            end
        end
        n_vec++;
        if (locked !== 1'b1 || grant_id !== 2'd3) begin
            n_err++; $display("FAIL to_before_release: got locked %b id %0d expected 1 3", locked, grant_id);
        end
        @(negedge clk);
        n_vec++;
        if ({locked, lock_err, bus.req_ready} !== 6'b0) begin
            n_err++; $display("FAIL to_released: got locked %b err %b ready %b expected 0 0 0000",
                              locked, lock_err, bus.req_ready);
        end
        @(negedge clk);
        n_vec++;
        if (bus.req_ready !== 4'b0001 || grant_id !== 2'd0) begin
            n_err++; $display("FAIL to_regrant: got ready %b id %0d expected 0001 0", bus.req_ready, grant_id);
        end
        wait_quiet(2, 40, ok);
        n_vec++;
        if (!ok || log_id[1] !== 2'd0 || log_data[1] !== 8'h30) begin
            n_err++; $display("FAIL to_byte: got id %0d data %h expected 0 30", log_id[1], log_data[1]);
        end
    endtask

    task automatic test_busy_hold();
        bit ok;
        int bad;
        do_reset();
        force_busy = 1'b1;
        push(2, 8'h62, 1'b1);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.req_ready !== 4'b0000 || bus.tx_start !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++; $display("FAIL busy_hold: got %0d active cycles expected 0", bad);
        end
        force_busy = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.req_ready !== 4'b0100) begin
            n_err++; $display("FAIL busy_release: got ready %b expected 0100", bus.req_ready);
        end
        wait_quiet(1, 40, ok);
        n_vec++;
        if (!ok || log_id[0] !== 2'd2 || log_data[0] !== 8'h62) begin
            n_err++; $display("FAIL busy_byte: got id %0d data %h expected 2 62", log_id[0], log_data[0]);
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int bad;
        do_reset();
        push(1, 8'h71, 1'b1);
        wait_log(1, 40, ok);
        repeat (2) @(negedge clk);
        n_vec++;
        if (!ok || grant_id !== 2'd1 || bus.tx_data !== 8'h71) begin
            n_err++; $display("FAIL mid_setup: got id %0d data %h expected 1 71", grant_id, bus.tx_data);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({bus.req_ready, bus.tx_start, bus.tx_data, grant_id, locked, lock_err} !== 17'h0) begin
            n_err++; $display("FAIL mid_reset_now: got %h expected 0",
                              {bus.req_ready, bus.tx_start, bus.tx_data, grant_id, locked, lock_err});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.req_ready !== 4'b0000 || bus.tx_start !== 1'b0 || locked !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++; $display("FAIL mid_stray_done: got %0d active cycles expected 0", bad);
        end
        push(0, 8'h70, 1'b1);
        push(1, 8'h72, 1'b1);
        wait_quiet(2, 80, ok);
        n_vec++;
        if (!ok || log_id[0] !== 2'd0 || log_id[1] !== 2'd1 || log_data[0] !== 8'h70) begin
            n_err++; $display("FAIL mid_regrant: got ids %0d %0d data %h expected 0 1 70",
                              log_id[0], log_id[1], log_data[0]);
        end
    endtask

    initial begin
        force_busy = 1'b0;
        inj_done   = 1'b0;
        test_reset();
        test_single_byte();
        test_round_robin();
        test_packet_lock();
        test_lock_timeout();
        test_busy_hold();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
